// File: rtl/pipe_pkg.sv
// Shared pipeline control definitions: memory-access encodings, ALUOp classes and
// the packed control bundle carried between pipeline registers.
package pipe_pkg;

  localparam int CTRL_ALUOP_W = 4;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_WORD = 2'b01;
  localparam logic [1:0] MEM_BYTE = 2'b10;
  localparam logic [1:0] MEM_HALF = 2'b11;

  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_NOP    = 4'b0000;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_RTYPE  = 4'b0010;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_LDST   = 4'b0100;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_BRANCH = 4'b0101;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_IMM    = 4'b0110;

  typedef struct packed {
    logic                    RegDst;
    logic                    Jump;
    logic                    Branch;
    logic [1:0]              MemRead;
    logic                    MemtoReg;
    logic [CTRL_ALUOP_W-1:0] ALUOp;
    logic [1:0]              MemWrite;
    logic                    ALUSrc;
    logic                    RegWrite;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic mem_active(input logic [1:0] m);
    return m != MEM_NONE;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_ctrl_sanitize.sv
// Combinational clean-up of a decoded control bundle so later stages never see
// contradictory combinations (jump with memory access, branch with writeback, ...).
module ctrl_sanitize
  import pipe_pkg::*;
(
  input  ctrl_t i_ctrl,
  output ctrl_t o_ctrl
);

  // Every rule is conditioned on the raw input so the result is order-independent.
  always_comb begin
    o_ctrl = i_ctrl;
    if (i_ctrl.Jump) begin
      o_ctrl.RegDst   = 1'b0;
      o_ctrl.MemtoReg = 1'b0;
      o_ctrl.ALUSrc   = 1'b0;
      o_ctrl.ALUOp    = '0;
      o_ctrl.MemRead  = MEM_NONE;
      o_ctrl.MemWrite = MEM_NONE;
    end
    if (i_ctrl.Branch) begin
      o_ctrl.RegWrite = 1'b0;
      o_ctrl.MemRead  = MEM_NONE;
      o_ctrl.MemWrite = MEM_NONE;
    end
    if (mem_active(i_ctrl.MemWrite)) begin
      o_ctrl.RegWrite = 1'b0;
      o_ctrl.MemtoReg = 1'b0;
    end
    if (mem_active(i_ctrl.MemRead) && mem_active(i_ctrl.MemWrite)) begin
      o_ctrl.MemRead  = MEM_NONE;
      o_ctrl.MemWrite = MEM_NONE;
      o_ctrl.RegWrite = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with bubble injection (flush / load-use hazard), EX stall hold
// and control sanitisation. Define IDEX_PERF_CNT_EN to add saturating bubble/stall counters.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hazard_detected,
  input  logic               flush,
  input  logic               stall_ex,
  input  logic               id_valid,
  input  logic               id_RegDst,
  input  logic               id_Jump,
  input  logic               id_Branch,
  input  logic               id_MemtoReg,
  input  logic               id_ALUSrc,
  input  logic               id_RegWrite,
  input  logic [1:0]         id_MemRead,
  input  logic [1:0]         id_MemWrite,
  input  logic [ALUOP_W-1:0] id_ALUOp,
  input  logic [DATA_W-1:0]  id_pc4,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [5:0]         id_funct,
  output logic               ex_valid,
  output logic               ex_RegDst,
  output logic               ex_Jump,
  output logic               ex_Branch,
  output logic               ex_MemtoReg,
  output logic               ex_ALUSrc,
  output logic               ex_RegWrite,
  output logic [1:0]         ex_MemRead,
  output logic [1:0]         ex_MemWrite,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [DATA_W-1:0]  ex_pc4,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [5:0]         ex_funct,
`ifdef IDEX_PERF_CNT_EN
  output logic [15:0]        perf_bubbles,
  output logic [15:0]        perf_stalls,
`endif
  output logic               bubble_pulse
);

  ctrl_t              w_id_ctrl;
  ctrl_t              w_san_ctrl;
  logic               w_bubble_req;

  ctrl_t              r_ctrl;
  logic               r_valid;
  logic               r_bubble_pulse;
  logic [DATA_W-1:0]  r_pc4;
  logic [DATA_W-1:0]  r_rs_data;
  logic [DATA_W-1:0]  r_rt_data;
  logic [DATA_W-1:0]  r_imm;
  logic [REG_AW-1:0]  r_rs;
  logic [REG_AW-1:0]  r_rt;
  logic [REG_AW-1:0]  r_rd;
  logic [5:0]         r_funct;

  assign w_id_ctrl = '{
    RegDst:   id_RegDst,
    Jump:     id_Jump,
    Branch:   id_Branch,
    MemRead:  id_MemRead,
    MemtoReg: id_MemtoReg,
    ALUOp:    id_ALUOp,
    MemWrite: id_MemWrite,
    ALUSrc:   id_ALUSrc,
    RegWrite: id_RegWrite
  };

  assign w_bubble_req = flush | hazard_detected;

  ctrl_sanitize u_ctrl_sanitize (
    .i_ctrl (w_id_ctrl),
    .o_ctrl (w_san_ctrl)
  );

  // ID -> EX boundary. Data fields load even on a bubble so their value stays deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl         <= CTRL_NOP;
      r_valid        <= 1'b0;
      r_bubble_pulse <= 1'b0;
      r_pc4          <= '0;
      r_rs_data      <= '0;
      r_rt_data      <= '0;
      r_imm          <= '0;
      r_rs           <= '0;
      r_rt           <= '0;
      r_rd           <= '0;
      r_funct        <= '0;
    end else if (stall_ex) begin
      r_bubble_pulse <= 1'b0;
    end else begin
      r_pc4     <= id_pc4;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
      r_funct   <= id_funct;
      if (w_bubble_req) begin
        r_ctrl         <= CTRL_NOP;
        r_valid        <= 1'b0;
        r_bubble_pulse <= 1'b1;
      end else begin
        r_ctrl         <= id_valid ? w_san_ctrl : CTRL_NOP;
        r_valid        <= id_valid;
        r_bubble_pulse <= 1'b0;
      end
    end
  end

`ifdef IDEX_PERF_CNT_EN
  logic [15:0] r_perf_bubbles;
  logic [15:0] r_perf_stalls;

  // Saturating event counters; a stalled edge never counts as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_bubbles <= '0;
      r_perf_stalls  <= '0;
    end else if (stall_ex) begin
      if (r_perf_stalls != 16'hFFFF) r_perf_stalls <= r_perf_stalls + 16'd1;
    end else if (w_bubble_req) begin
      if (r_perf_bubbles != 16'hFFFF) r_perf_bubbles <= r_perf_bubbles + 16'd1;
    end
  end

  assign perf_bubbles = r_perf_bubbles;
  assign perf_stalls  = r_perf_stalls;
`endif

  assign ex_valid     = r_valid;
  assign ex_RegDst    = r_ctrl.RegDst;
  assign ex_Jump      = r_ctrl.Jump;
  assign ex_Branch    = r_ctrl.Branch;
  assign ex_MemtoReg  = r_ctrl.MemtoReg;
  assign ex_ALUSrc    = r_ctrl.ALUSrc;
  assign ex_RegWrite  = r_ctrl.RegWrite;
  assign ex_MemRead   = r_ctrl.MemRead;
  assign ex_MemWrite  = r_ctrl.MemWrite;
  assign ex_ALUOp     = r_ctrl.ALUOp;
  assign ex_pc4       = r_pc4;
  assign ex_rs_data   = r_rs_data;
  assign ex_rt_data   = r_rt_data;
  assign ex_imm       = r_imm;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_rd        = r_rd;
  assign ex_funct     = r_funct;
  assign bubble_pulse = r_bubble_pulse;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register, directly downstream of the decode-stage control unit and register file.
- Latches the control bundle, operands, immediate and register specifiers each cycle.
- Injects bubbles on load-use hazard or control flush, and holds on an execute-side stall.
- Sanitises the control bundle so EX/MEM/WB never see don't-care or illegal combinations.

Parameters:
DATA_W, 32, operand/PC/immediate width
REG_AW, 5, register specifier width
ALUOP_W, 4, ALUOp width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
hazard_detected  in  1  load-use hazard from hazard unit; insert bubble
flush  in  1  taken branch/jump redirect; kill instruction in ID
stall_ex  in  1  downstream hold; keep current contents
id_valid  in  1  ID holds a real instruction
id_RegDst, id_Jump, id_Branch, id_MemtoReg, id_ALUSrc, id_RegWrite  in  1 each  control from decode
id_MemRead, id_MemWrite  in  2 each  00 none, 01 word, 10 byte, 11 half
id_ALUOp  in  ALUOP_W  ALU operation class
id_pc4  in  DATA_W  PC+4
id_rs_data, id_rt_data  in  DATA_W  register file read data
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  REG_AW  register specifiers
id_funct  in  6  R-type function field
ex_valid  out  1  EX holds a real instruction
ex_* (one per id_* above)  out  same width  registered copies
bubble_pulse  out  1  registered; high the cycle after a bubble was written

Behaviour:
- Reset (async, rst_n=0): all outputs 0, including ex_valid and bubble_pulse. Deassertion takes effect at the next clk edge.
- Latency: 1 cycle, ID inputs to ex_* outputs.
- Per-edge priority, highest first:
  - stall_ex=1: every register holds; bubble_pulse <= 0. flush/hazard are ignored this cycle; upstream re-presents them.
  - flush=1: bubble written.
  - hazard_detected=1: bubble written.
  - Otherwise: load the ID values, ex_valid <= id_valid.
- Bubble:
  - ex_valid, all control outputs and ex_ALUOp <= 0; bubble_pulse <= 1.
  - Data/specifier fields are loaded normally. They are don't-care but must be deterministic.
- Control inputs are never sampled while hazard_detected=1; the decoder output is stale then.
- Sanitisation on a normal load:
  - id_Jump=1: RegDst, MemtoReg, ALUSrc, ALUOp, MemRead, MemWrite forced 0.
  - id_Branch=1: RegWrite, MemRead, MemWrite forced 0.
  - id_MemWrite!=0: RegWrite, MemtoReg forced 0.
  - id_MemRead!=0 and id_MemWrite!=0 together: both forced 0, RegWrite forced 0, ex_valid still loads id_valid.
  - id_valid=0: loaded as a bubble, but bubble_pulse stays 0.
- flush and hazard together produce one bubble; bubble_pulse=1.
- Reset asserted mid-stall clears immediately; no held state survives.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_bubbles[15:0] and perf_stalls[15:0], both saturating at 16'hFFFF.
  - perf_bubbles increments on each edge where a hazard/flush bubble is written.
  - perf_stalls increments on each edge with stall_ex=1.
  - Both clear on reset.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - MEM_NONE/MEM_WORD/MEM_BYTE/MEM_HALF 2-bit encodings.
  - ALUOp constants.
  - Packed typedef ctrl_t bundling RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite.
  - CTRL_NOP constant (all zero).
- One sub-module, ctrl_sanitize: purely combinational ctrl_t to ctrl_t, implementing the forcing rules. Reusable by the EX/MEM register.

Test Plan:
- Reset: drive inputs nonzero, rst_n=0 between edges -> all outputs 0 immediately; first edge after release loads ID.
- lw (MemRead=01, RegWrite=1, ALUOp=0100, imm=0x0000_0010) -> next cycle ex_MemRead=01, ex_RegWrite=1, ex_imm=0x10, ex_valid=1, bubble_pulse=0.
- beq with id_RegWrite=1, Branch=1, ALUOp=0101 -> ex_Branch=1, ex_RegWrite=0, ex_ALUOp=0101.
- hazard_detected=1 for 1 cycle during add -> bubble: ex_valid=0, ex_RegWrite=0, bubble_pulse=1; next cycle add loads normally.
- stall_ex=1 for 3 cycles with flush=1 in cycle 2 -> outputs frozen all 3 cycles, no bubble; perf_stalls=3 with IDEX_PERF_CNT_EN.
- j with id_ALUOp=1111, id_ALUSrc=1 -> ex_Jump=1, ex_ALUOp=0000, ex_ALUSrc=0, ex_MemWrite=00.
